// File: rtl/seq_divider_unit_if.sv
// Issue/completion bundle for the sequential divider functional unit.
// The master issues operations; the slave (the divider) returns results and status.
interface seq_divider_unit_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 5
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic [TAG_W-1:0]     tag_in;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic [TAG_W-1:0]     tag_out;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, dividend, divisor, tag_in,
        input  busy, done, quotient, remainder, tag_out, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor, tag_in,
        output busy, done, quotient, remainder, tag_out, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider_unit.sv
// Restoring unsigned divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are detected at issue and complete without iterating.
module seq_divider_unit #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_divider_unit_if.slave    div_if
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_prem;
    logic [WIDTH-1:0]   r_low;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [TAG_W-1:0]   r_tag;
    logic               r_dbz;
    logic               r_ovf;

    logic               r_done;
    logic [WIDTH-1:0]   r_q_out;
    logic [WIDTH-1:0]   r_r_out;
    logic [TAG_W-1:0]   r_tag_out;
    logic               r_dbz_out;
    logic               r_ovf_out;

    logic               w_accept;
    logic               w_step;
    logic               w_finish;
    logic               w_dbz;
    logic               w_ovf;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;

    assign w_dbz = (div_if.divisor == '0);
    assign w_ovf = (div_if.dividend[2*WIDTH-1:WIDTH] >= div_if.divisor);

    // Shifted partial remainder is W+1 bits; a successful trial difference is
    // always below the divisor, so the low W bits of the subtraction are exact.
    assign w_shift = {r_prem, r_low[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[WIDTH-1:0] - r_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The done pulse is shown in the first IDLE cycle, so hold off issue there.
                if (div_if.start && !r_done) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_dbz || w_ovf) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_count == CNT_W'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_finish     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_prem    <= '0;
            r_low     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_tag     <= '0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            r_q_out   <= '0;
            r_r_out   <= '0;
            r_tag_out <= '0;
            r_dbz_out <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag     <= div_if.tag_in;
                r_div     <= div_if.divisor;
                r_count   <= CNT_W'(WIDTH);
                r_dbz     <= w_dbz;
                r_ovf     <= !w_dbz && w_ovf;
                r_dbz_out <= 1'b0;
                r_ovf_out <= 1'b0;
                if (w_dbz || w_ovf) begin
                    r_quo  <= '1;
                    r_prem <= div_if.dividend[WIDTH-1:0];
                    r_low  <= '0;
                end else begin
                    r_quo  <= '0;
                    r_prem <= div_if.dividend[2*WIDTH-1:WIDTH];
                    r_low  <= div_if.dividend[WIDTH-1:0];
                end
            end else if (w_step) begin
                r_prem  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                r_quo   <= {r_quo[WIDTH-2:0], w_ge};
                r_low   <= {r_low[WIDTH-2:0], 1'b0};
                r_count <= r_count - CNT_W'(1);
            end

            r_done <= w_finish;
            if (w_finish) begin
                r_q_out   <= r_quo;
                r_r_out   <= r_prem;
                r_tag_out <= r_tag;
                r_dbz_out <= r_dbz;
                r_ovf_out <= r_ovf;
            end
        end
    end

    assign div_if.busy        = (r_state != S_IDLE) || r_done;
    assign div_if.done        = r_done;
    assign div_if.quotient    = r_q_out;
    assign div_if.remainder   = r_r_out;
    assign div_if.tag_out     = r_tag_out;
    assign div_if.div_by_zero = r_dbz_out;
    assign div_if.overflow    = r_ovf_out;

endmodule
